// File: rtl/zoom_address_unit.sv
// Framebuffer address generator for a windowed VGA display with zoom and pan.
// The pipeline runs in three stages: window offset, mode mapping, then pixel gating.
module zoom_address_unit #(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240,
  parameter int unsigned H_OFF = 160,
  parameter int unsigned V_OFF = 120,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0]       next_x,
  input  logic [9:0]       next_y,
  input  logic [1:0]       mode_sel,
  input  logic [8:0]       pan_x,
  input  logic [7:0]       pan_y,
  output logic [7:0]       linha,
  output logic [8:0]       coluna,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [PIX_W-1:0] color,
  output logic [1:0]       mode_active,
  output logic             frame_start
);

  localparam int unsigned AW = 12;

  localparam logic [AW-1:0] X_LO    = AW'(H_OFF);
  localparam logic [AW-1:0] X_HI    = AW'(H_OFF + IMG_W);
  localparam logic [AW-1:0] Y_LO    = AW'(V_OFF);
  localparam logic [AW-1:0] Y_HI    = AW'(V_OFF + IMG_H);
  localparam logic [AW-1:0] LIM_W   = AW'(IMG_W);
  localparam logic [AW-1:0] LIM_H   = AW'(IMG_H);
  localparam logic [AW-1:0] PAN2_X  = AW'(IMG_W / 2);
  localparam logic [AW-1:0] PAN2_Y  = AW'(IMG_H / 2);
  localparam logic [AW-1:0] PAN4_X  = AW'((3 * IMG_W) / 4);
  localparam logic [AW-1:0] PAN4_Y  = AW'((3 * IMG_H) / 4);
  localparam logic [AW-1:0] QTR_W   = AW'(IMG_W / 4);
  localparam logic [AW-1:0] QTR3_W  = AW'((3 * IMG_W) / 4);
  localparam logic [AW-1:0] QTR_H   = AW'(IMG_H / 4);
  localparam logic [AW-1:0] QTR3_H  = AW'((3 * IMG_H) / 4);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_ZOOM2  = 2'd1,
    MODE_ZOOM4  = 2'd2,
    MODE_HALF   = 2'd3
  } mode_t;

  // Frame boundary and clamped pan values for the shadow latch
  logic          boundary_c;
  logic [AW-1:0] req_px_c;
  logic [AW-1:0] req_py_c;
  logic [AW-1:0] lim_px_c;
  logic [AW-1:0] lim_py_c;

  assign boundary_c = (next_x == 10'd0) && (next_y == 10'd0);
  assign req_px_c   = AW'(pan_x);
  assign req_py_c   = AW'(pan_y);

  always_comb begin
    lim_px_c = '0;
    lim_py_c = '0;
    case (mode_t'(mode_sel))
      MODE_ZOOM2: begin
        lim_px_c = (req_px_c > PAN2_X) ? PAN2_X : req_px_c;
        lim_py_c = (req_py_c > PAN2_Y) ? PAN2_Y : req_py_c;
      end
      MODE_ZOOM4: begin
        lim_px_c = (req_px_c > PAN4_X) ? PAN4_X : req_px_c;
        lim_py_c = (req_py_c > PAN4_Y) ? PAN4_Y : req_py_c;
      end
      default: begin
        lim_px_c = '0;
        lim_py_c = '0;
      end
    endcase
  end

  // Shadow settings: only change on the frame boundary so a frame never mixes modes
  mode_t         shadow_mode;
  logic [AW-1:0] shadow_px;
  logic [AW-1:0] shadow_py;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_mode <= MODE_NORMAL;
      shadow_px   <= '0;
      shadow_py   <= '0;
      frame_start <= 1'b0;
      mode_active <= 2'd0;
    end else begin
      if (boundary_c) begin
        shadow_mode <= mode_t'(mode_sel);
        shadow_px   <= lim_px_c;
        shadow_py   <= lim_py_c;
      end
      frame_start <= boundary_c;
      mode_active <= shadow_mode;
    end
  end

  // Stage 1: offset into the image window; below-offset values wrap but are flagged invalid
  logic [AW-1:0] x_ext_c;
  logic [AW-1:0] y_ext_c;
  logic          in_win_c;
  logic [AW-1:0] s1_dx;
  logic [AW-1:0] s1_dy;
  logic          s1_in_win;

  assign x_ext_c  = AW'(next_x);
  assign y_ext_c  = AW'(next_y);
  assign in_win_c = (x_ext_c >= X_LO) && (x_ext_c < X_HI) &&
                    (y_ext_c >= Y_LO) && (y_ext_c < Y_HI);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_in_win <= 1'b0;
    end else begin
      s1_dx     <= x_ext_c - X_LO;
      s1_dy     <= y_ext_c - Y_LO;
      s1_in_win <= in_win_c;
    end
  end

  // Stage 2: mode mapping from window offset to framebuffer coordinates
  logic [AW-1:0] col_c;
  logic [AW-1:0] lin_c;
  logic          mode_ok_c;
  logic          valid_c;

  always_comb begin
    col_c     = s1_dx;
    lin_c     = s1_dy;
    mode_ok_c = 1'b1;
    case (shadow_mode)
      MODE_ZOOM2: begin
        col_c = shadow_px + (s1_dx >> 1);
        lin_c = shadow_py + (s1_dy >> 1);
      end
      MODE_ZOOM4: begin
        col_c = shadow_px + (s1_dx >> 2);
        lin_c = shadow_py + (s1_dy >> 2);
      end
      MODE_HALF: begin
        mode_ok_c = (s1_dx >= QTR_W) && (s1_dx < QTR3_W) &&
                    (s1_dy >= QTR_H) && (s1_dy < QTR3_H);
        col_c     = (s1_dx - QTR_W) << 1;
        lin_c     = (s1_dy - QTR_H) << 1;
      end
      default: begin
        col_c = s1_dx;
        lin_c = s1_dy;
      end
    endcase
    valid_c = s1_in_win && mode_ok_c && (col_c < LIM_W) && (lin_c < LIM_H);
  end

  logic s2_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      linha    <= '0;
      coluna   <= '0;
      s2_valid <= 1'b0;
    end else begin
      linha    <= valid_c ? 8'(lin_c) : 8'd0;
      coluna   <= valid_c ? 9'(col_c) : 9'd0;
      s2_valid <= valid_c;
    end
  end

  // Stage 3: framebuffer data returns one cycle after the address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      color <= '0;
    end else begin
      color <= s2_valid ? pixel_in : '0;
    end
  end

endmodule

// File: tb/tb_zoom_address_unit.sv
// Bench for zoom_address_unit: directed scenarios with literal expectations,
// then randomized traffic against a cycle-indexed behavioural model.
module tb_zoom_address_unit;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int H_OFF = 160;
  localparam int V_OFF = 120;
  localparam int N     = 4096;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] next_x = 10'd1023;
  logic [9:0] next_y = 10'd1023;
  logic [1:0] mode_sel = 2'd0;
  logic [8:0] pan_x = 9'd0;
  logic [7:0] pan_y = 8'd0;
  logic [7:0] linha;
  logic [8:0] coluna;
  logic [7:0] pixel_in = 8'd0;
  logic [7:0] color;
  logic [1:0] mode_active;
  logic       frame_start;

  zoom_address_unit #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .H_OFF(H_OFF), .V_OFF(V_OFF), .PIX_W(8)
  ) dut (
    .clock(clock), .reset(reset), .next_x(next_x), .next_y(next_y),
    .mode_sel(mode_sel), .pan_x(pan_x), .pan_y(pan_y), .linha(linha),
    .coluna(coluna), .pixel_in(pixel_in), .color(color),
    .mode_active(mode_active), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int lastrst = -1;

  // Model state: settings in force, and per-input-cycle expectations
  int m_mode = 0, m_px = 0, m_py = 0;
  int ex_lin[N];
  int ex_col[N];
  bit ex_val[N];
  bit ex_bnd[N];
  int ex_mode[N];
  int pixv[N];

  int req_m = 0, req_px = 0, req_py = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // What the framebuffer coordinates must be for one display position
  task automatic model_addr(input int x, input int y, output int l, output int c, output bit v);
    int dx, dy;
    bit ok;
    dx = x - H_OFF;
    dy = y - V_OFF;
    ok = (dx >= 0) && (dx < IMG_W) && (dy >= 0) && (dy < IMG_H);
    case (m_mode)
      1: begin c = m_px + dx / 2; l = m_py + dy / 2; end
      2: begin c = m_px + dx / 4; l = m_py + dy / 4; end
      3: begin
        ok = ok && (dx >= IMG_W / 4) && (dx < 3 * IMG_W / 4) &&
             (dy >= IMG_H / 4) && (dy < 3 * IMG_H / 4);
        c = (dx - IMG_W / 4) * 2;
        l = (dy - IMG_H / 4) * 2;
      end
      default: begin c = dx; l = dy; end
    endcase
    v = ok && (c < IMG_W) && (l < IMG_H);
    if (!v) begin c = 0; l = 0; end
  endtask

  task automatic model_cycle(input int x, input int y, input int m, input int px,
                             input int py, input int pix, input bit rst);
    int l, c;
    bit v;
    pixv[cyc] = pix;
    if (!rst) begin
      lastrst = cyc;
      m_mode = 0; m_px = 0; m_py = 0;
      ex_val[cyc] = 0; ex_bnd[cyc] = 0; ex_mode[cyc] = 0;
      ex_lin[cyc] = 0; ex_col[cyc] = 0;
    end else begin
      ex_bnd[cyc] = (x == 0) && (y == 0);
      if (ex_bnd[cyc]) begin
        m_mode = m;
        if (m == 1) begin m_px = min2(px, IMG_W / 2); m_py = min2(py, IMG_H / 2); end
        else if (m == 2) begin m_px = min2(px, 3 * IMG_W / 4); m_py = min2(py, 3 * IMG_H / 4); end
        else begin m_px = 0; m_py = 0; end
      end
      ex_mode[cyc] = m_mode;
      model_addr(x, y, l, c, v);
      ex_lin[cyc] = l; ex_col[cyc] = c; ex_val[cyc] = v;
    end
  endtask

  task automatic check_outputs();
    int el, ec, ecol, em, ef;
    el = 0; ec = 0; ecol = 0; em = 0; ef = 0;
    if (cyc >= 2 && cyc - 2 > lastrst) begin
      el = ex_lin[cyc-2];
      ec = ex_col[cyc-2];
      em = ex_mode[cyc-2];
    end
    if (cyc >= 3 && cyc - 3 > lastrst && ex_val[cyc-3]) ecol = pixv[cyc-1];
    if (cyc >= 1 && cyc - 1 > lastrst && ex_bnd[cyc-1]) ef = 1;
    chk("linha", int'(linha), el);
    chk("coluna", int'(coluna), ec);
    chk("color", int'(color), ecol);
    chk("mode_active", int'(mode_active), em);
    chk("frame_start", int'(frame_start), ef);
  endtask

  // One clock cycle: check the outputs the previous edges produced, then drive new inputs
  task automatic step(input int x, input int y, input int m, input int px,
                      input int py, input int pix, input bit rst);
    bit prev_rst;
    @(posedge clock);
    #1;
    prev_rst = reset;
    check_outputs();
    next_x   = 10'(x);
    next_y   = 10'(y);
    mode_sel = 2'(m);
    pan_x    = 9'(px);
    pan_y    = 8'(py);
    pixel_in = 8'(pix);
    reset    = rst;
    model_cycle(x, y, m, px, py, pix, rst);
    if (!rst && prev_rst) begin
      #1;
      chk("rst_linha", int'(linha), 0);
      chk("rst_coluna", int'(coluna), 0);
      chk("rst_color", int'(color), 0);
      chk("rst_mode_active", int'(mode_active), 0);
      chk("rst_frame_start", int'(frame_start), 0);
    end
    cyc++;
  endtask

  task automatic idle(input int pix);
    step(1023, 1023, req_m, req_px, req_py, pix, 1'b1);
  endtask

  initial begin
    int rst_left;
    int x, y;
    bit r;

    repeat (3) step(1023, 1023, 0, 0, 0, 0, 1'b0);

    // Before any boundary the block stays in mode 0 regardless of requests
    req_m = 2; req_px = 50; req_py = 50;
    step(160, 120, 2, 50, 50, 0, 1'b1);
    idle(0);
    idle(8'hA5);
    chk("m0_linha", int'(linha), 0);
    chk("m0_coluna", int'(coluna), 0);
    idle(0);
    chk("m0_color", int'(color), 8'hA5);

    // Zoom 2x with pan (10,5)
    req_m = 1; req_px = 10; req_py = 5;
    step(0, 0, 1, 10, 5, 0, 1'b1);
    step(165, 123, 1, 10, 5, 0, 1'b1);
    chk("z2_frame_start", int'(frame_start), 1);
    idle(0);
    idle(0);
    chk("z2_coluna", int'(coluna), 12);
    chk("z2_linha", int'(linha), 6);

    // Zoom 4x with oversized pan gets clamped
    req_m = 2; req_px = 400; req_py = 250;
    step(0, 0, 2, 400, 250, 0, 1'b1);
    step(160, 120, 2, 400, 250, 0, 1'b1);
    idle(0);
    chk("z4_mode_active", int'(mode_active), 2);
    idle(0);
    chk("z4_coluna", int'(coluna), 240);
    chk("z4_linha", int'(linha), 180);

    // Zoom-out: image centred, outer ring blank
    req_m = 3; req_px = 77; req_py = 77;
    step(0, 0, 3, 77, 77, 0, 1'b1);
    step(160, 120, 3, 77, 77, 0, 1'b1);
    step(240, 180, 3, 77, 77, 0, 1'b1);
    idle(8'h11);
    idle(8'h22);
    chk("half_coluna", int'(coluna), 0);
    chk("half_color_edge", int'(color), 0);
    idle(0);
    chk("half_color_centre", int'(color), 8'h22);

    // Mid-frame request change has no effect until the boundary
    req_m = 0; req_px = 0; req_py = 0;
    step(260, 190, 0, 0, 0, 0, 1'b1);
    idle(0);
    chk("mid_frame_start", int'(frame_start), 0);
    idle(0);
    chk("mid_coluna", int'(coluna), 40);
    chk("mid_linha", int'(linha), 20);
    chk("mid_mode_active", int'(mode_active), 3);
    step(0, 0, 0, 0, 0, 0, 1'b1);
    step(260, 190, 0, 0, 0, 0, 1'b1);
    chk("new_frame_start", int'(frame_start), 1);
    idle(0);
    chk("new_frame_start_end", int'(frame_start), 0);
    chk("new_mode_active", int'(mode_active), 0);
    idle(0);
    chk("new_coluna", int'(coluna), 100);
    chk("new_linha", int'(linha), 70);

    // Reset mid-line in zoom 2x
    req_m = 1; req_px = 0; req_py = 0;
    step(0, 0, 1, 0, 0, 0, 1'b1);
    repeat (3) step(200, 150, 1, 0, 0, 8'h3C, 1'b1);
    chk("pre_rst_coluna", int'(coluna), 20);
    chk("pre_rst_linha", int'(linha), 15);
    step(200, 150, 1, 0, 0, 8'h3C, 1'b0);
    step(200, 150, 1, 0, 0, 8'h3C, 1'b0);
    step(200, 150, 1, 0, 0, 8'h3C, 1'b1);
    idle(0);
    idle(0);
    chk("post_rst_mode_active", int'(mode_active), 0);
    chk("post_rst_coluna", int'(coluna), 40);
    chk("post_rst_linha", int'(linha), 30);

    // Randomized traffic with frequent boundaries, setting changes and occasional resets
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        x = 0; y = 0;
      end else begin
        x = int'($urandom_range(120, 520));
        y = int'($urandom_range(90, 400));
      end
      if ($urandom_range(0, 7) == 0) begin
        req_m  = int'($urandom_range(0, 3));
        req_px = int'($urandom_range(0, 511));
        req_py = int'($urandom_range(0, 255));
      end
      if (rst_left > 0) begin
        r = 1'b0;
        rst_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        r = 1'b0;
        rst_left = int'($urandom_range(0, 2));
      end else begin
        r = 1'b1;
      end
      step(x, y, req_m, req_px, req_py, int'($urandom_range(0, 255)), r);
    end
    idle(0);
    idle(0);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
